sound_event_detector: RTL
=========================

Name: sound_event_detector

Overview:
- Downstream consumer of the microphone stage's filtered 16-bit signed audio stream (32 kHz, single-cycle valid strobes on the 98.304 MHz clock).
- Computes a leaky attack/decay magnitude envelope per sample.
- Runs a hysteresis and hold state machine on the envelope, flagging sound events (e.g. a meow) for downstream game/control logic.

Parameters:
- ATTACK_SHIFT, 2, envelope rise rate: step = error >> ATTACK_SHIFT.
- DECAY_SHIFT, 8, envelope fall rate: step = error >> DECAY_SHIFT.
- HOLD_SAMPLES, 3200, samples the envelope must stay below thresh_off before an event ends (100 ms at 32 kHz). Must be >= 1.

Ports:
- clk_in  input  1  system clock (98.304 MHz). Sole clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- audio_data  input  16  signed audio sample.
- audio_valid  input  1  sample strobe. May be high on consecutive cycles.
- thresh_on  input  16  unsigned envelope level that starts an event.
- thresh_off  input  16  unsigned envelope level below which hold countdown runs.
- level_out  output  16  unsigned envelope integer part.
- level_valid  output  1  1-cycle pulse when level_out updates.
- active_out  output  1  high while an event is in progress (ACTIVE or HOLD).
- event_start  output  1  1-cycle pulse on IDLE->ACTIVE.
- event_end  output  1  1-cycle pulse on HOLD->IDLE.
- peak_clear  input  1  clears peak_out (PEAK_HOLD_EN only).
- peak_out  output  16  max magnitude since last clear (PEAK_HOLD_EN only).

Behaviour:
- Reset (async assert, sync-safe deassert):
  - env = 0, state = IDLE, hold_cnt = 0.
  - All outputs 0.
  - Reset mid-event drops to IDLE with no event_end pulse.
- Magnitude:
  - mag = |audio_data|, saturated: -32768 -> 32767.
  - Range 0..32767.
- Envelope register: env is 24-bit unsigned, 16 integer bits + 8 fraction bits; m = mag << 8.
- Envelope update, only on cycles with audio_valid:
  - if m > env: env <= env + ((m - env) >> ATTACK_SHIFT).
  - else: env <= env - ((env - m) >> DECAY_SHIFT).
  - Shifts are logical and truncating.
  - env never exceeds 32767<<8 and never underflows.
- Level output:
  - level_out = env[23:8], registered.
  - level_valid pulses the cycle after audio_valid (latency 1).
- FSM evaluation:
  - Evaluated on level_valid cycles using the new level_out; state and pulses update 1 cycle later (latency 2 from audio_valid).
  - Effective off threshold: eff_off = min(thresh_off, thresh_on).
  - Thresholds are sampled on each evaluation.
- FSM states:
  - IDLE: level >= thresh_on -> ACTIVE, pulse event_start.
  - ACTIVE: level < eff_off -> HOLD, load hold_cnt = HOLD_SAMPLES-1.
  - HOLD: evaluated in this priority order:
    - level >= thresh_on -> ACTIVE, no event_start.
    - else hold_cnt == 0 -> IDLE, pulse event_end.
    - else hold_cnt decrements.
    - Levels between eff_off and thresh_on do not reload the counter.
- active_out = (state != IDLE), registered.
- Pulse exclusivity: event_start and event_end are never high in the same cycle.
- Back-to-back samples: audio_valid on every cycle must produce a correct update every cycle (fully pipelined, no stall).
- Cycles without audio_valid leave env, state and hold_cnt unchanged.
- thresh_on = 0: IDLE->ACTIVE on the first evaluation; event cannot end.

Optional Feature:
- Macro: SOUND_EVENT_PEAK_HOLD_EN.
- Defined:
  - peak_out is a register updated on audio_valid: peak <= max(peak, mag).
  - peak_clear has priority over an update in the same cycle and loads the current mag if audio_valid, else 0.
  - Reset value 0.
- Undefined:
  - peak_out tied to 0; peak_clear ignored.
  - No peak logic synthesised.

Test Plan:
- Reset, audio_data = 0 for 100 samples -> level_out = 0, active_out = 0, no pulses.
- Defaults, env = 0, samples 16384, 16384 -> level_out = 4096 then 7168, each level_valid 1 cycle after audio_valid.
- Single sample -32768 from env = 0 -> mag saturates to 32767, level_out = 8191.
- thresh_on = 8000, thresh_off = 4000, 16384 burst then zeros:
  - event_start once, 2 cycles after the first sample taking level >= 8000.
  - Zero samples continue until level < 4000.
  - event_end exactly HOLD_SAMPLES evaluations after HOLD entry; active_out falls with it.
- In HOLD, reapply 16384 burst before countdown expires -> back to ACTIVE, no second event_start, no event_end.
- Assert rst_n_in mid-ACTIVE with audio_valid continuous every cycle -> outputs 0 asynchronously, no event_end. After release, a new event is detected normally. With PEAK_HOLD_EN, peak_out = 0 after reset, and peak_clear concurrent with sample 100 gives peak_out = 100.

Source files
------------

// File: rtl/sound_event_detector.sv
// sound_event_detector: attack/decay audio envelope follower with hysteresis + hold event FSM
// Ports:
//   clk_in, rst_n_in           sole clock, asynchronous active-low reset
//   audio_data, audio_valid    signed 16-bit samples with single-cycle strobes (may be back-to-back)
//   thresh_on, thresh_off      unsigned envelope levels that start an event / arm the hold countdown
//   level_out, level_valid     envelope integer part and its 1-cycle update pulse
//   active_out                 high while an event is in progress (ACTIVE or HOLD)
//   event_start, event_end     1-cycle pulses on IDLE->ACTIVE and HOLD->IDLE
//   peak_clear, peak_out       peak-magnitude register, present only with SOUND_EVENT_PEAK_HOLD_EN
module sound_event_detector #(
    parameter int ATTACK_SHIFT = 2,
    parameter int DECAY_SHIFT  = 8,
    parameter int HOLD_SAMPLES = 3200
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [15:0] audio_data,
    input  logic        audio_valid,
    input  logic [15:0] thresh_on,
    input  logic [15:0] thresh_off,
    output logic [15:0] level_out,
    output logic        level_valid,
    output logic        active_out,
    output logic        event_start,
    output logic        event_end,
    input  logic        peak_clear,
    output logic [15:0] peak_out
);
    localparam int HW = $clog2(HOLD_SAMPLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_SAMPLES - 1);
    typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;
    logic [15:0]   mag, eff_off;
    logic [23:0]   m, env, env_d;
    logic [HW-1:0] hold_cnt, hold_d;
    logic          start_d, end_d;
    state_t        state, state_d;
    // -32768 has no positive counterpart, so it saturates to 32767
    assign mag = !audio_data[15] ? audio_data : (audio_data == 16'h8000) ? 16'h7fff : 16'd0 - audio_data;
    assign m = {mag, 8'h00};
    // each step is a fraction of the gap, so env can never overshoot m or wrap below zero
    assign env_d = (m > env) ? env + ((m - env) >> ATTACK_SHIFT) : env - ((env - m) >> DECAY_SHIFT);
    assign level_out = env[23:8];
    assign eff_off = (thresh_off < thresh_on) ? thresh_off : thresh_on;
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            env         <= '0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= audio_valid;
            if (audio_valid) env <= env_d;
        end
    end
    always_comb begin
        state_d = state;
        hold_d  = hold_cnt;
        start_d = 1'b0;
        end_d   = 1'b0;
        if (level_valid) begin
            case (state)
                IDLE: if (level_out >= thresh_on) begin
                    state_d = ACTIVE;
                    start_d = 1'b1;
                end
                ACTIVE: if (level_out < eff_off) begin
                    state_d = HOLD;
                    hold_d  = HOLD_LOAD;
                end
                HOLD: if (level_out >= thresh_on) state_d = ACTIVE;
                    else if (hold_cnt == '0) begin
                        state_d = IDLE;
                        end_d   = 1'b1;
                    end else hold_d = hold_cnt - 1'b1;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            active_out  <= 1'b0;
            event_start <= 1'b0;
            event_end   <= 1'b0;
        end else begin
            state       <= state_d;
            hold_cnt    <= hold_d;
            active_out  <= (state_d != IDLE);
            event_start <= start_d;
            event_end   <= end_d;
        end
    end
`ifdef SOUND_EVENT_PEAK_HOLD_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) peak_out <= '0;
        else if (peak_clear) peak_out <= audio_valid ? mag : 16'd0;
        else if (audio_valid && mag > peak_out) peak_out <= mag;
    end
`else
    logic unused_peak_clear;
    assign unused_peak_clear = peak_clear;
    assign peak_out = '0;
`endif
endmodule
